// File: rtl/servo_seq_pkg.sv
// Shared types and default timing constants for the servo motion sequencer.
package servo_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // Defaults for a 50 MHz system clock
  localparam int DEF_STEP_CYCLES = 1_000_000;  // 20 ms per program step
  localparam int DEF_RAMP_CYCLES = 50_000;     // 1 ms slew update period
  localparam int DEF_MAX_DELTA   = 4;          // position units per slew update

endpackage

// File: rtl/servo_slew.sv
// Per-axis servo position register.
// With SERVO_SEQUENCER_SLEW_EN defined, the position walks toward the target
// by at most MAX_DELTA on each ramp tick; otherwise it is a plain one-cycle
// copy of the target.
module servo_slew #(
  parameter int DATA_W    = 8
`ifdef SERVO_SEQUENCER_SLEW_EN
  ,
  parameter int MAX_DELTA = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SERVO_SEQUENCER_SLEW_EN
  input  logic              tick,
`endif
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pos
);

`ifdef SERVO_SEQUENCER_SLEW_EN
  // One bit wider than the data so a large MAX_DELTA is not truncated
  localparam logic [DATA_W:0] STEP = (DATA_W + 1)'(MAX_DELTA);

  logic              up;
  logic [DATA_W-1:0] diff;

  // Distance is always taken as larger minus smaller, so it never wraps
  assign up   = (target >= pos);
  assign diff = up ? (target - pos) : (pos - target);

  // Snap to target when close enough, otherwise move one bounded step toward it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (tick) begin
      if ({1'b0, diff} <= STEP) begin
        pos <= target;
      end else if (up) begin
        pos <= pos + STEP[DATA_W-1:0];
      end else begin
        pos <= pos - STEP[DATA_W-1:0];
      end
    end
  end
`else
  // Position follows target with one cycle of latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else begin
      pos <= target;
    end
  end
`endif

endmodule

// File: rtl/servo_sequencer.sv
// Motion-program sequencer for the three-servo arm: walks one address across
// the X/Y/Z position ROMs at a fixed step rate and latches each word into a
// per-axis position register.
// Optional build macro: SERVO_SEQUENCER_SLEW_EN (rate-limited position slewing).
module servo_sequencer
  import servo_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int RAMP_CYCLES = DEF_RAMP_CYCLES,
  parameter int MAX_DELTA   = DEF_MAX_DELTA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data_x,
  input  logic [DATA_W-1:0] rom_data_y,
  input  logic [DATA_W-1:0] rom_data_z,
  output logic [DATA_W-1:0] pos_x,
  output logic [DATA_W-1:0] pos_y,
  output logic [DATA_W-1:0] pos_z,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W    = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  // Reject parameter sets the step and slew logic cannot honour
  if (STEP_CYCLES < 2 || RAMP_CYCLES < 1 || MAX_DELTA < 1) begin : g_bad_params
    $error("servo_sequencer: STEP_CYCLES>=2, RAMP_CYCLES>=1, MAX_DELTA>=1 required");
  end

  seq_state_t        state;
  logic [CNT_W-1:0]  step_cnt;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] target_x, target_y, target_z;
  logic              step_end;
  logic              finishing;

  assign step_end  = (step_cnt == CNT_LAST);
  // Last step expiring with looping off ends the program
  assign finishing = step_end && (rom_address == last_q) && !loop_en;

  // Control FSM: stop beats start, start beats pause; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rom_address <= '0;
      step_cnt    <= '0;
      last_q      <= '0;
      target_x    <= '0;
      target_y    <= '0;
      target_z    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the pre-edge
      // values, so the default below and later overrides behave as intended.
      done <= 1'b0;
      if (stop) begin
        // Targets are left untouched so the servos hold their last position
        state       <= S_IDLE;
        rom_address <= '0;
        step_cnt    <= '0;
        busy        <= 1'b0;
      end else if (start && (state == S_IDLE || state == S_DONE)) begin
        state       <= S_RUN;
        rom_address <= '0;
        step_cnt    <= '0;
        last_q      <= last_addr;
        busy        <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            target_x <= rom_data_x;
            target_y <= rom_data_y;
            target_z <= rom_data_z;
            if (step_end) begin
              step_cnt <= '0;
              // Wrap by explicit compare against the latched last step
              if (rom_address != last_q) begin
                rom_address <= rom_address + 1'b1;
              end else if (loop_en) begin
                rom_address <= '0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
            if (finishing) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (pause) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!pause) state <= S_RUN;
          end
          default: begin
            // IDLE and DONE hold address and targets until start or stop
          end
        endcase
      end
    end
  end

`ifdef SERVO_SEQUENCER_SLEW_EN
  localparam int                RAMP_W    = $clog2(RAMP_CYCLES + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);

  logic [RAMP_W-1:0] ramp_cnt;
  logic              ramp_tick;

  assign ramp_tick = (ramp_cnt == RAMP_LAST);

  // Free-running ramp timebase, independent of sequencer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
    end
  end
`endif

  servo_slew #(
    .DATA_W   (DATA_W)
`ifdef SERVO_SEQUENCER_SLEW_EN
    ,
    .MAX_DELTA(MAX_DELTA)
`endif
  ) u_slew_x (
    .clk   (clk),
    .rst   (rst),
`ifdef SERVO_SEQUENCER_SLEW_EN
    .tick  (ramp_tick),
`endif
    .target(target_x),
    .pos   (pos_x)
  );

  servo_slew #(
    .DATA_W   (DATA_W)
`ifdef SERVO_SEQUENCER_SLEW_EN
    ,
    .MAX_DELTA(MAX_DELTA)
`endif
  ) u_slew_y (
    .clk   (clk),
    .rst   (rst),
`ifdef SERVO_SEQUENCER_SLEW_EN
    .tick  (ramp_tick),
`endif
    .target(target_y),
    .pos   (pos_y)
  );

  servo_slew #(
    .DATA_W   (DATA_W)
`ifdef SERVO_SEQUENCER_SLEW_EN
    ,
    .MAX_DELTA(MAX_DELTA)
`endif
  ) u_slew_z (
    .clk   (clk),
    .rst   (rst),
`ifdef SERVO_SEQUENCER_SLEW_EN
    .tick  (ramp_tick),
`endif
    .target(target_z),
    .pos   (pos_z)
  );

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer: reset, single run, looping, pause,
// stop/start collision and asynchronous reset (plus slewing when built with
// SERVO_SEQUENCER_SLEW_EN).
module tb_servo_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, pause, loop_en;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data_x, rom_data_y, rom_data_z;
  logic [DATA_W-1:0] pos_x, pos_y, pos_z;
  logic              busy, done;

  int tests_run    = 0;
  int tests_failed = 0;

  servo_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STEP_CYCLES(10),
    .RAMP_CYCLES(2),
    .MAX_DELTA  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .last_addr  (last_addr),
    .rom_address(rom_address),
    .rom_data_x (rom_data_x),
    .rom_data_y (rom_data_y),
    .rom_data_z (rom_data_z),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_z      (pos_z),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Program ROMs: x = 10*addr, y = 255 - addr, z = 0x80
  assign rom_data_x = DATA_W'(rom_address * 8'd10);
  assign rom_data_y = 8'd255 - rom_address;
  assign rom_data_z = 8'h80;

  // Advance one clock; land 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    last_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    tests_run++;
    if (rom_address !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: addr=%0d busy=%b done=%b, want 0/0/0", rom_address, busy, done);
    end
    tests_run++;
    if (pos_x !== 8'd0 || pos_y !== 8'd0 || pos_z !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_pos: pos=%0d/%0d/%0d, want 0/0/0", pos_x, pos_y, pos_z);
    end
  endtask

  task automatic test_single_run();
    int done_pulses = 0;
    last_addr = 8'd3; loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tests_run++;
      if (rom_address !== ADDR_W'(i / 10) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_step cyc %0d: addr=%0d busy=%b, want %0d/1", i, rom_address, busy, i / 10);
      end
      if (done === 1'b1) done_pulses++;
      tick();
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || rom_address !== 8'd3) begin
      tests_failed++;
      $display("FAIL single_done: done=%b busy=%b addr=%0d, want 1/0/3", done, busy, rom_address);
    end
    tests_run++;
    if (pos_x !== 8'd30 || pos_y !== 8'd252 || pos_z !== 8'h80) begin
      tests_failed++;
      $display("FAIL single_pos: pos=%0d/%0d/%0d, want 30/252/128", pos_x, pos_y, pos_z);
    end
    if (done === 1'b1) done_pulses++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) done_pulses++;
    end
    tests_run++;
    if (done_pulses != 1 || rom_address !== 8'd3 || pos_x !== 8'd30) begin
      tests_failed++;
      $display("FAIL single_hold: pulses=%0d addr=%0d pos_x=%0d, want 1/3/30", done_pulses, rom_address, pos_x);
    end
  endtask

  task automatic test_loop();
    int done_pulses = 0;
    last_addr = 8'd3; loop_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 55; i++) begin
      tests_run++;
      if (rom_address !== ADDR_W'((i / 10) % 4) || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL loop_step cyc %0d: addr=%0d busy=%b, want %0d/1", i, rom_address, busy, (i / 10) % 4);
      end
      if (done === 1'b1) done_pulses++;
      tick();
    end
    tests_run++;
    if (done_pulses != 0) begin
      tests_failed++;
      $display("FAIL loop_no_done: pulses=%0d, want 0", done_pulses);
    end
    loop_en = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || rom_address !== 8'd0) begin
      tests_failed++;
      $display("FAIL loop_stop: busy=%b addr=%0d, want 0/0", busy, rom_address);
    end
  endtask

  task automatic test_pause();
    int waited;
    last_addr = 8'd3; loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    // Counter reads 4 during the cycle whose closing edge first samples pause
    repeat (4) tick();
    pause = 1'b1;
    repeat (7) tick();
    pause = 1'b0;
    tests_run++;
    if (rom_address !== 8'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL pause_hold: addr=%0d busy=%b, want 0/1", rom_address, busy);
    end
    // Unpaused, address 1 would appear 10 edges after start; paused, 17
    waited = 0;
    while (rom_address === 8'd0 && waited < 30) begin
      tick();
      waited++;
    end
    tests_run++;
    if (waited != 6 || rom_address !== 8'd1) begin
      tests_failed++;
      $display("FAIL pause_delay: change after %0d more cycles to addr %0d, want 6 to 1", waited, rom_address);
    end
    waited = 0;
    while (rom_address === 8'd1 && waited < 30) begin
      tick();
      waited++;
    end
    tests_run++;
    if (waited != 10 || rom_address !== 8'd2) begin
      tests_failed++;
      $display("FAIL pause_next: addr 1 held %0d cycles then %0d, want 10 then 2", waited, rom_address);
    end
  endtask

  task automatic test_stop_start();
    repeat (3) tick();
    tests_run++;
    if (pos_x !== 8'd20 || rom_address !== 8'd2) begin
      tests_failed++;
      $display("FAIL ss_pre: pos_x=%0d addr=%0d, want 20/2", pos_x, rom_address);
    end
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || rom_address !== 8'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_ctrl: busy=%b addr=%0d done=%b, want 0/0/0", busy, rom_address, done);
    end
    repeat (5) tick();
    tests_run++;
    if (pos_x !== 8'd20 || pos_y !== 8'd253 || pos_z !== 8'h80 || busy !== 1'b0 || rom_address !== 8'd0) begin
      tests_failed++;
      $display("FAIL ss_hold: pos=%0d/%0d/%0d busy=%b addr=%0d, want 20/253/128/0/0",
               pos_x, pos_y, pos_z, busy, rom_address);
    end
  endtask

  task automatic test_async_reset();
    last_addr = 8'd3; loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (15) tick();
    tests_run++;
    if (rom_address !== 8'd1 || pos_x === 8'd0) begin
      tests_failed++;
      $display("FAIL areset_pre: addr=%0d pos_x=%0d, want 1/nonzero", rom_address, pos_x);
    end
    // Assert between edges: outputs must clear without waiting for a clock
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (rom_address !== 8'd0 || pos_x !== 8'd0 || pos_y !== 8'd0 || pos_z !== 8'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_now: addr=%0d pos=%0d/%0d/%0d busy=%b done=%b, want all 0",
               rom_address, pos_x, pos_y, pos_z, busy, done);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (busy !== 1'b0 || rom_address !== 8'd0 || pos_x !== 8'd0) begin
      tests_failed++;
      $display("FAIL areset_after: busy=%b addr=%0d pos_x=%0d, want 0/0/0", busy, rom_address, pos_x);
    end
  endtask

`ifdef SERVO_SEQUENCER_SLEW_EN
  task automatic test_slew();
    logic [DATA_W-1:0] prev;
    int since_change = 99;
    int bad_steps    = 0;
    last_addr = 8'd3; loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    prev = pos_x;
    for (int i = 0; i < 60; i++) begin
      tick();
      since_change++;
      if (pos_x !== prev) begin
        if (pos_x < prev || pos_x - prev > 4 || since_change < 2) bad_steps++;
        since_change = 0;
        prev = pos_x;
      end
    end
    tests_run++;
    if (bad_steps != 0 || pos_x !== 8'd30) begin
      tests_failed++;
      $display("FAIL slew_ramp: bad steps=%0d final pos_x=%0d, want 0/30", bad_steps, pos_x);
    end
    // Restart: target falls back to 0, so pos_x ramps down from 30
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (pos_x === 8'd30 || pos_x === 8'd0) begin
      tests_failed++;
      $display("FAIL slew_mid: pos_x=%0d, want strictly between 0 and 30", pos_x);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (pos_x !== 8'd0 || pos_y !== 8'd0 || pos_z !== 8'd0 || busy !== 1'b0 || rom_address !== 8'd0) begin
      tests_failed++;
      $display("FAIL slew_reset: pos=%0d/%0d/%0d busy=%b addr=%0d, want all 0",
               pos_x, pos_y, pos_z, busy, rom_address);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef SERVO_SEQUENCER_SLEW_EN
    test_slew();
`else
    test_single_run();
    test_loop();
    test_pause();
    test_stop_start();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
